// File: rtl/ant_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default address width / reset PC.
package ant_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_STALL,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Registered FIFO for fetched instructions: push/pop in the same cycle are
// allowed even when full; flush empties it on the same edge.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        do_push, do_pop;

    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        empty     = (cnt_q == '0);
        count     = cnt_q;
        head_data = mem_q[rd_q];
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        mem_d     = mem_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses
// with their PC, and drops responses made stale by a redirect.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instruction_fetch
    import ant_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              QDEPTH   = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d, stale_q, stale_d;
    logic [CW-1:0]   q_count, occ_d;
    logic            q_full, q_empty;
    logic [2*XLEN-1:0] q_head;
    logic            pop_raw, req_hs, rsp_stale, push, pop;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({pc_of_rsp(), imem_rsp_data}),
        .pop       (pop),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // PC of the oldest live request = current pc minus the live requests in flight.
    function automatic logic [XLEN-1:0] pc_of_rsp();
        return pc_q - (XLEN'(outst_q) << 2);
    endfunction

    always_comb begin
        inst_valid = !q_empty;
        inst_pc    = q_head[2*XLEN-1:XLEN];
        inst_data  = q_head[XLEN-1:0];
        pop_raw    = inst_valid && inst_ready;
        // In STALL the slot freed by this cycle's pop is reused at once,
        // which keeps a 1-cycle memory streaming one instruction per cycle.
        imem_req_valid = (state_q == ST_FETCH) || ((state_q == ST_STALL) && pop_raw);
        imem_req_addr  = pc_q;
        req_hs     = imem_req_valid && imem_req_ready;
        rsp_stale  = imem_rsp_valid && (stale_q != '0);
        pop        = pop_raw && !redirect_valid;
        push       = imem_rsp_valid && !rsp_stale && !redirect_valid && (!q_full || pop);

        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q;
        stale_d = stale_q;
        occ_d   = '0;
        if (redirect_valid) begin
            // Everything in flight, including this cycle's handshake, goes stale.
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            stale_d = stale_q + outst_q + CW'(req_hs) - CW'(imem_rsp_valid);
            outst_d = '0;
            state_d = ST_DRAIN;
        end else begin
            if (req_hs) pc_d = pc_q + XLEN'(4);
            if (rsp_stale) stale_d = stale_q - CW'(1);
            outst_d = outst_q + CW'(req_hs) - CW'(imem_rsp_valid && !rsp_stale);
            occ_d   = q_count + CW'(push) - CW'(pop);
            case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH,
                ST_STALL: state_d = (outst_d + occ_d == CW'(QDEPTH)) ? ST_STALL : ST_FETCH;
                ST_DRAIN: state_d = (stale_d == '0) ? ST_FETCH : ST_DRAIN;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            stale_q <= stale_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_stall_d   = perf_stall_q + 32'(!inst_valid && (state_q != ST_BOOT));
        perf_fetched   = perf_fetched_q;
        perf_stall     = perf_stall_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a memory model answers accepted
// requests in order, and a scoreboard checks the decoded PC/data stream.
module tb_instruction_fetch;

    localparam int QD = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        w_req_valid, w_inst_valid;
    logic [31:0] w_req_addr, w_inst_data, w_inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    // Second instance only exercises PC wrap-around from the top of memory.
    instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(QD)) dut_wrap (
        .clock(clock), .reset_n(reset_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0),
        .imem_rsp_data(32'h0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .inst_valid(w_inst_valid), .inst_ready(1'b0),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc;
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    int          p_ready, p_rsp, p_iready;
    logic [31:0] exp_pc, exp_req;
    logic        do_redirect;
    logic [31:0] redir_target;
    int          acc_since, pops_total;
    logic        popped_now, hs_now;
    logic [31:0] last_pop_pc, last_hs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
    endfunction

    // One clock: drive inputs at the falling edge, score what the rising edge will do.
    task automatic step();
        imem_req_ready = ($urandom_range(99) < p_ready);
        inst_ready     = ($urandom_range(99) < p_iready);
        redirect_valid = do_redirect;
        redirect_pc    = redir_target;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend_addr.size() > 0 && pend_cyc[0] < cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
        end
        #1;
        popped_now = 1'b0;
        hs_now     = 1'b0;
        if (inst_valid && inst_ready && !redirect_valid) begin
            tests_run++;
            if (inst_pc !== exp_pc) begin
                tests_failed++;
                $display("FAIL pop_pc: got %h, expected %h", inst_pc, exp_pc);
            end
            tests_run++;
            if (inst_data !== mem_word(exp_pc)) begin
                tests_failed++;
                $display("FAIL pop_data: got %h, expected %h (pc %h)", inst_data, mem_word(exp_pc), exp_pc);
            end
            last_pop_pc = inst_pc;
            exp_pc      = exp_pc + 32'd4;
            popped_now  = 1'b1;
            pops_total++;
        end
        if (imem_req_valid && imem_req_ready) begin
            tests_run++;
            if (imem_req_addr !== exp_req) begin
                tests_failed++;
                $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_req);
            end
            pend_addr.push_back(imem_req_addr);
            pend_cyc.push_back(cyc);
            exp_req      = exp_req + 32'd4;
            last_hs_addr = imem_req_addr;
            hs_now       = 1'b1;
            if (!redirect_valid) acc_since++;
        end
        if (redirect_valid) begin
            exp_pc    = {redir_target[31:2], 2'b00};
            exp_req   = {redir_target[31:2], 2'b00};
            acc_since = 0;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
        do_redirect = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
        do_redirect = 0; redir_target = 0;
        p_ready = 0; p_rsp = 0; p_iready = 0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req_valid=%b inst_valid=%b data=%h pc=%h, expected all 0",
                     imem_req_valid, inst_valid, inst_data, inst_pc);
        end
        @(negedge clock);
        reset_n = 1'b1;
        pend_addr.delete(); pend_cyc.delete();
        cyc = 0; exp_pc = 32'h0; exp_req = 32'h0; acc_since = 0; pops_total = 0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || w_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_no_req: req_valid=%b wrap_valid=%b, expected 0", imem_req_valid, w_req_valid);
        end
        step();
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_fetch: valid=%b addr=%h inst_valid=%b, expected 1/00000000/0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
        tests_run++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_first: valid=%b addr=%h, expected 1/fffffffc", w_req_valid, w_req_addr);
        end
        step();
        tests_run++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_second: valid=%b addr=%h, expected 1/00000000", w_req_valid, w_req_addr);
        end
        tests_run++;
        if (w_inst_valid !== 1'b0 || w_inst_data !== 32'h0 || w_inst_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_idle_queue: valid=%b data=%h pc=%h, expected 0", w_inst_valid, w_inst_data, w_inst_pc);
        end
    endtask

    task automatic test_streaming();
        int late = 0;
        p_ready = 100; p_rsp = 100; p_iready = 100;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i >= 10 && popped_now) late++;
        end
        tests_run++;
        if (late != 20) begin
            tests_failed++;
            $display("FAIL stream_rate: got %0d pops in 20 cycles, expected 20", late);
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        p_ready = 100; p_rsp = 100; p_iready = 0;
        do_redirect = 1'b1; redir_target = 32'h200;
        step();
        repeat (20) step();
        tests_run++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_stall: req_valid=%b inst_valid=%b, expected 0/1", imem_req_valid, inst_valid);
        end
        tests_run++;
        if (acc_since != QD || pend_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_buffered: accepted=%0d pending=%0d, expected %0d/0", acc_since, pend_addr.size(), QD);
        end
        p_iready = 100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (popped_now) pops++;
        end
        tests_run++;
        if (pops < 15) begin
            tests_failed++;
            $display("FAIL bp_resume: got %0d pops in 20 cycles, expected >= 15", pops);
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        p_ready = 100; p_rsp = 100; p_iready = 100;
        repeat (10) step();
        p_rsp = 0;
        repeat (6) step();
        tests_run++;
        if (pend_addr.size() != QD || imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_setup: outstanding=%0d req_valid=%b, expected %0d/0", pend_addr.size(), imem_req_valid, QD);
        end
        p_rsp = 100;
        do_redirect = 1'b1; redir_target = 32'h100;
        step();
        tests_run++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_drain: req_valid=%b inst_valid=%b, expected 0/0", imem_req_valid, inst_valid);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = popped_now;
        end
        tests_run++;
        if (!found || last_pop_pc !== 32'h100) begin
            tests_failed++;
            $display("FAIL redir_target: found=%0d pc=%h, expected 1/00000100", found, last_pop_pc);
        end
    endtask

    task automatic test_redirect_full();
        bit found = 0;
        p_ready = 100; p_rsp = 100; p_iready = 0;
        repeat (10) step();
        tests_run++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_setup: inst_valid=%b req_valid=%b, expected 1/0", inst_valid, imem_req_valid);
        end
        p_iready = 100;
        do_redirect = 1'b1; redir_target = 32'h302;
        step();
        tests_run++;
        if (inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_flush: inst_valid=%b, expected 0", inst_valid);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = hs_now;
        end
        tests_run++;
        if (!found || last_hs_addr !== 32'h300) begin
            tests_failed++;
            $display("FAIL full_newpc: found=%0d addr=%h, expected 1/00000300", found, last_hs_addr);
        end
    endtask

    task automatic test_random();
        int start = pops_total;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                p_ready  = $urandom_range(100, 20);
                p_rsp    = $urandom_range(100, 20);
                p_iready = $urandom_range(100, 20);
            end
            if ($urandom_range(99) < 3) begin
                do_redirect  = 1'b1;
                redir_target = $urandom;
            end
            step();
        end
        tests_run++;
        if (pops_total - start < 100) begin
            tests_failed++;
            $display("FAIL rand_progress: got %0d pops, expected >= 100", pops_total - start);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, address and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter QDEPTH, default 2, fetch-queue entries (power of two, 2..8).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 SHALL have port imem_rsp_valid  input  1  response valid (in order, one per accepted request, at least 1 cycle after acceptance).
REQ-010 SHALL have port imem_rsp_data  input  XLEN  fetched instruction word.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-012 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-013 SHALL have port inst_valid  output  1  instruction available to decode.
REQ-014 SHALL have port inst_ready  input  1  decode consumes instruction.
REQ-015 SHALL have port inst_data  output  XLEN  instruction to decode.
REQ-016 SHALL have port inst_pc  output  XLEN  PC of inst_data.

Function
REQ-017 SHALL implement FSM BOOT -> FETCH <-> STALL, and any state -> DRAIN on redirect; DRAIN -> FETCH when stale count reaches 0.
REQ-018 SHALL spend exactly one cycle in BOOT after reset release, with imem_req_valid=0.
REQ-019 SHALL, in FETCH, assert imem_req_valid with imem_req_addr=pc; handshake = valid&ready; pc += 4 on handshake; addr stable while valid&!ready.
REQ-020 SHALL enter STALL when outstanding requests + queue occupancy = QDEPTH, deassert imem_req_valid there, and return to FETCH when a slot frees.
REQ-021 SHALL push each non-stale response into the queue with its PC; queue full on a valid response is impossible by REQ-020.
REQ-022 SHALL present queue head on inst_data/inst_pc with inst_valid=!empty; pop on inst_valid&inst_ready.
REQ-023 SHALL allow push and pop in the same cycle, occupancy unchanged, including when full.
REQ-024 SHALL zero-latency bypass nothing: response-to-inst_valid latency is 1 cycle (registered queue).
REQ-025 SHALL, on redirect_valid, flush the queue the same edge, set pc=redirect_pc, mark all outstanding requests stale, and drop their responses.
REQ-026 SHALL in DRAIN issue no requests; if stale count is already 0, go directly to FETCH next cycle.
REQ-027 SHALL give redirect priority over a simultaneous pop, push or request handshake (handshaked request that cycle counts as stale).
REQ-028 SHALL force redirect_pc[1:0] to 00.
REQ-029 SHALL wrap pc modulo 2^XLEN without error.

Reset
REQ-030 SHALL on reset_n=0 asynchronously set state=BOOT, pc=RESET_PC, queue empty, outstanding=0, stale=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-031 SHALL discard, after reset mid-operation, any responses to pre-reset requests only if the environment delivers them; the memory is reset with the same reset_n.

Configuration
REQ-032 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetched (32-bit, count of instructions popped) and perf_stall (32-bit, cycles with inst_valid=0 and state!=BOOT), both reset to 0 and wrapping.
REQ-033 SHALL, without FETCH_PERF_EN, have neither port nor counter logic.

Structure
REQ-034 SHALL take the fetch state enum, XLEN default and RESET_PC default from shared package ant_pkg.
REQ-035 SHALL implement the queue as sub-module fetch_queue (parameterised depth/width, push/pop/flush, full/empty).

Verification
REQ-036 SHALL verify reset: reset_n low 3 cycles then high -> BOOT 1 cycle, then imem_req_addr=0x0 valid, inst_valid=0.
REQ-037 SHALL verify streaming: ready=1, 1-cycle memory, inst_ready=1 -> inst_pc 0x0,0x4,0x8,... one per cycle, data matching memory.
REQ-038 SHALL verify backpressure: inst_ready=0 -> exactly QDEPTH instructions buffered, imem_req_valid=0 (STALL), no loss when inst_ready returns.
REQ-039 SHALL verify redirect: redirect to 0x100 with 2 outstanding -> both stale responses dropped, next inst_pc=0x100.
REQ-040 SHALL verify simultaneous redirect and pop at full queue -> queue empty next cycle, pc=redirect_pc.
REQ-041 SHALL verify wrap: RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
